// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding and parity-mode constants.
// Used by uart_rx_param and its interface/sub-modules.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-word valid/ready channel of the parametrised UART receiver.
// master = receiver (word source), slave = register/FIFO layer (word sink).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] out_data;
  logic                 out_frame_err;
  logic                 out_parity_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data,
    output out_frame_err,
    output out_parity_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_frame_err,
    input  out_parity_err,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous UART lines; resets to 1 (idle line).
// Shared by the receiver (rx) and the transmitter (cts).
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a one-word valid/ready holding register.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   tick,
  input  logic                   rx,
  uart_rx_param_if.master        out_if,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD))
  begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter combination");
  end

  logic rx_s;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 ferr, ferr_n;
  logic                 stop_idx, stop_idx_n;
  logic                 commit;
  logic                 commit_ferr;
  logic                 perr_now;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ACTIVE = (PARITY_MODE != PAR_NONE);
  localparam logic PAR_EXPECT = (PARITY_MODE == PAR_ODD);
  logic perr, perr_n;
  assign perr_now = perr;
`else
  assign perr_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      ferr     <= 1'b0;
      stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      ferr     <= ferr_n;
      stop_idx <= stop_idx_n;
`ifdef UART_RX_PARITY_EN
      perr     <= perr_n;
`endif
    end
  end

  // Every sample point is a counter match on a tick; dropping en aborts any frame.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    ferr_n      = ferr;
    stop_idx_n  = stop_idx;
    commit      = 1'b0;
    commit_ferr = ferr;
`ifdef UART_RX_PARITY_EN
    perr_n      = perr;
`endif

    if (state != IDLE && !en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (tick && en && !rx_s) begin
            state_n = START;
            cnt_n   = CNT_W'(1);
          end
        end
        START: begin
          if (tick) begin
            if (cnt == CNT_MID) begin
              if (!rx_s) begin
                state_n = DATA;
                cnt_n   = '0;
                idx_n   = '0;
              end else begin
                state_n = IDLE;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt == CNT_LAST) begin
              shreg_n[idx] = rx_s;
              cnt_n        = '0;
              idx_n        = idx + 1'b1;
              if (idx == IDX_LAST) begin
                ferr_n     = 1'b0;
                stop_idx_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_n     = 1'b0;
                state_n    = PAR_ACTIVE ? PARITY : STOP;
`else
                state_n    = STOP;
`endif
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (cnt == CNT_LAST) begin
              perr_n  = ((^shreg) ^ rx_s) != PAR_EXPECT;
              cnt_n   = '0;
              state_n = STOP;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (cnt == CNT_LAST) begin
              cnt_n       = '0;
              commit_ferr = ferr | ~rx_s;
              ferr_n      = commit_ferr;
              if (stop_idx == STOP_LAST) begin
                commit  = 1'b1;
                state_n = commit_ferr ? BRK_WAIT : IDLE;
              end else begin
                stop_idx_n = 1'b1;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        BRK_WAIT: begin
          if (rx_s) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  logic [DATA_BITS-1:0] data_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic                 valid_q;

  // Holding register: a commit wins over a same-cycle transfer; a full, unread register drops the new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit && (!valid_q || out_if.out_ready)) begin
        data_q  <= shreg;
        ferr_q  <= commit_ferr;
        perr_q  <= perr_now;
        valid_q <= 1'b1;
      end else begin
        if (commit) begin
          overrun <= 1'b1;
        end
        if (valid_q && out_if.out_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_if.out_data       = data_q;
  assign out_if.out_frame_err  = ferr_q;
  assign out_if.out_parity_err = perr_q;
  assign out_if.out_valid      = valid_q;
  assign busy                  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance plus a 7-bit even-parity instance.
// Parity-error expectation follows UART_RX_PARITY_EN.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic tick = 1'b0;
  logic rx_a;
  logic rx_b;
  logic ready_a;
  logic overrun_a, busy_a;
  logic overrun_b, busy_b;

  int tests = 0;
  int fails = 0;
  int div   = 0;

  always #5 clk = ~clk;

  // Tick every fourth clock, changed on the falling edge so it is stable at posedge.
  always @(negedge clk) begin
    div  = (div == 3) ? 0 : div + 1;
    tick = (div == 0);
  end

  uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_param_if #(.DATA_BITS(7)) bus_b ();

  assign bus_a.out_ready = ready_a;
  assign bus_b.out_ready = 1'b1;

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .tick(tick), .rx(rx_a),
    .out_if(bus_a), .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(
    .DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .tick(tick), .rx(rx_b),
    .out_if(bus_b), .overrun(overrun_b), .busy(busy_b)
  );

  int         rises_a = 0, rises_b = 0, overruns_a = 0;
  logic       prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] last_data_a = '0;
  logic       last_ferr_a = 1'b0, last_perr_a = 1'b0;
  logic [6:0] last_data_b = '0;
  logic       last_ferr_b = 1'b0, last_perr_b = 1'b0;

  // Capture every delivered word, since out_valid may last only one cycle.
  always @(negedge clk) begin
    if (bus_a.out_valid && !prev_a) begin
      rises_a++;
      last_data_a = bus_a.out_data;
      last_ferr_a = bus_a.out_frame_err;
      last_perr_a = bus_a.out_parity_err;
    end
    prev_a = bus_a.out_valid;
    if (bus_b.out_valid && !prev_b) begin
      rises_b++;
      last_data_b = bus_b.out_data;
      last_ferr_b = bus_b.out_frame_err;
      last_perr_b = bus_b.out_parity_err;
    end
    prev_b = bus_b.out_valid;
    if (overrun_a) overruns_a++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic b, input int ticks);
    #1;
    if (sel == 0) rx_a = b;
    else          rx_b = b;
    wait_ticks(ticks);
  endtask

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = 0; i < n; i++) begin
      apply_stimulus(sel, v[i], 16);
    end
  endtask

  int base_r;
  int base_o;

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    ready_a = 1'b1;
    repeat (4) @(negedge clk);

    check_output("rst_valid",  bus_a.out_valid, 0);
    check_output("rst_data",   bus_a.out_data, 0);
    check_output("rst_ferr",   bus_a.out_frame_err, 0);
    check_output("rst_perr",   bus_a.out_parity_err, 0);
    check_output("rst_overrun", overrun_a, 0);
    check_output("rst_busy",   busy_a, 0);

    reset_n = 1'b1;
    en      = 1'b1;
    wait_ticks(4);

    // Clean 8N1 frame with the consumer always ready.
    base_r = rises_a;
    send_bits(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    apply_stimulus(0, 1'b1, 8);
    check_output("a5_rises", rises_a - base_r, 1);
    check_output("a5_data",  last_data_a, 8'hA5);
    check_output("a5_ferr",  last_ferr_a, 0);
    check_output("a5_perr",  last_perr_a, 0);

    // Stop bit low followed by a held break.
    base_r = rises_a;
    send_bits(0, {6'h00, 1'b0, 8'h3C, 1'b0}, 10);
    apply_stimulus(0, 1'b0, 48);
    check_output("brk_rises", rises_a - base_r, 1);
    check_output("brk_data",  last_data_a, 8'h3C);
    check_output("brk_ferr",  last_ferr_a, 1);
    check_output("brk_busy_held", busy_a, 1);
    apply_stimulus(0, 1'b1, 16);
    check_output("brk_busy_released", busy_a, 0);
    check_output("brk_no_extra", rises_a - base_r, 1);

    // Two frames against a stalled consumer.
    ready_a = 1'b0;
    base_r  = rises_a;
    base_o  = overruns_a;
    send_bits(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
    apply_stimulus(0, 1'b1, 8);
    @(negedge clk);
    check_output("ovr_rises", rises_a - base_r, 1);
    check_output("ovr_valid", bus_a.out_valid, 1);
    check_output("ovr_data",  bus_a.out_data, 8'h11);
    check_output("ovr_pulses", overruns_a - base_o, 1);
    ready_a = 1'b1;
    @(negedge clk);
    check_output("ovr_drain", bus_a.out_valid, 0);

    // Short low glitch must be rejected as a false start.
    base_r = rises_a;
    base_o = overruns_a;
    apply_stimulus(0, 1'b0, 4);
    apply_stimulus(0, 1'b1, 32);
    check_output("glitch_busy",  busy_a, 0);
    check_output("glitch_rises", rises_a - base_r, 0);
    check_output("glitch_ovr",   overruns_a - base_o, 0);

    // Enable dropped in the middle of the data bits.
    base_r = rises_a;
    send_bits(0, {12'h000, 3'b101, 1'b0}, 4);
    #1 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("en_busy", busy_a, 0);
    apply_stimulus(0, 1'b1, 24);
    #1 en = 1'b1;
    wait_ticks(200);
    check_output("en_rises", rises_a - base_r, 0);

    // Reset mid-frame with a word still held.
    ready_a = 1'b0;
    send_bits(0, {6'h3f, 1'b1, 8'h5A, 1'b0}, 10);
    apply_stimulus(0, 1'b1, 8);
    @(negedge clk);
    check_output("rst_held_valid", bus_a.out_valid, 1);
    send_bits(0, {12'h000, 3'b011, 1'b0}, 4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_output("midrst_valid",   bus_a.out_valid, 0);
    check_output("midrst_data",    bus_a.out_data, 0);
    check_output("midrst_busy",    busy_a, 0);
    check_output("midrst_overrun", overrun_a, 0);
    check_output("midrst_ferr",    bus_a.out_frame_err, 0);
    check_output("midrst_perr",    bus_a.out_parity_err, 0);
    rx_a    = 1'b1;
    ready_a = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(4);

    // 7-bit frame 0x55 with the even-parity bit inverted (1 instead of 0).
    base_r = rises_b;
    send_bits(1, {5'h1f, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
    apply_stimulus(1, 1'b1, 8);
    check_output("par_rises", rises_b - base_r, 1);
    check_output("par_data",  last_data_b, 7'h55);
    check_output("par_ferr",  last_ferr_b, 0);
`ifdef UART_RX_PARITY_EN
    check_output("par_perr",  last_perr_b, 1);
`else
    check_output("par_perr",  last_perr_b, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
